// File: rtl/fast_core_code_mem_arbiter.sv
// Code memory arbiter: port A belongs to instruction fetch, port B is shared between fetch
// and an aux requester (MOVC reads / loader writes) with a starvation limit for aux.
module fast_core_code_mem_arbiter #(
  parameter int unsigned PC_BITWIDTH  = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_reset,
  input  logic                   fetch_re_A,
  input  logic                   fetch_re_B,
  input  logic [PC_BITWIDTH-1:0] fetch_addr_A,
  input  logic [PC_BITWIDTH-1:0] fetch_addr_B,
  output logic                   fetch_stall,
  output logic                   fetch_valid,
  output logic [DATA_WIDTH-1:0]  fetch_data_A,
  output logic [DATA_WIDTH-1:0]  fetch_data_B,
  input  logic                   aux_req,
  input  logic                   aux_we,
  input  logic [PC_BITWIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0]  aux_wdata,
  output logic                   aux_ack,
  output logic                   aux_rvalid,
  output logic [DATA_WIDTH-1:0]  aux_rdata,
  output logic                   mem_re_A,
  output logic [PC_BITWIDTH-1:0] mem_addr_A,
  output logic                   mem_re_B,
  output logic                   mem_we_B,
  output logic [PC_BITWIDTH-1:0] mem_addr_B,
  output logic [DATA_WIDTH-1:0]  mem_wdata_B,
  input  logic [DATA_WIDTH-1:0]  mem_q_A,
  input  logic [DATA_WIDTH-1:0]  mem_q_B
);

  localparam int unsigned StarveW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LatW    = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [LatW-1:0]    LatMax    = LatW'(MEM_LATENCY);

  typedef enum logic [2:0] {
    StHold = 3'b001,
    StRun  = 3'b010,
    StAux  = 3'b100
  } state_e;

  state_e                 state_q;
  logic [StarveW-1:0]     starve_q;
  logic [LatW-1:0]        aux_left_q;
  logic [MEM_LATENCY-1:0] fetch_tag_q;
  logic [MEM_LATENCY-1:0] aux_tag_q;

  logic running;
  logic in_run;
  logic aux_grant;
  logic fetch_b;
  logic fetch_issue;

  // sync_reset overrides everything in its cycle, so it also masks this cycle's grants.
  always_comb begin
    running     = !sync_reset && (state_q != StHold);
    in_run      = !sync_reset && (state_q == StRun);
    aux_grant   = in_run && aux_req && (!fetch_re_B || (starve_q == StarveMax));
    fetch_stall = aux_grant && fetch_re_B;
    fetch_b     = running && fetch_re_B && !aux_grant;

    mem_re_A    = running && fetch_re_A && !fetch_stall;
    mem_addr_A  = running ? fetch_addr_A : '0;

    mem_re_B    = aux_grant ? !aux_we : fetch_b;
    mem_we_B    = aux_grant && aux_we;
    mem_addr_B  = aux_grant ? aux_addr : (running ? fetch_addr_B : '0);
    mem_wdata_B = aux_grant ? aux_wdata : '0;
    aux_ack     = aux_grant;

    fetch_issue = mem_re_A || fetch_b;
  end

  always_comb begin
    fetch_valid  = fetch_tag_q[MEM_LATENCY-1];
    aux_rvalid   = aux_tag_q[MEM_LATENCY-1];
    fetch_data_A = fetch_valid ? mem_q_A : '0;
    fetch_data_B = fetch_valid ? mem_q_B : '0;
    aux_rdata    = aux_rvalid ? mem_q_B : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StHold;
      starve_q    <= '0;
      aux_left_q  <= '0;
      fetch_tag_q <= '0;
      aux_tag_q   <= '0;
    end else if (sync_reset) begin
      state_q     <= StHold;
      starve_q    <= '0;
      aux_left_q  <= '0;
      fetch_tag_q <= '0;
      aux_tag_q   <= '0;
    end else begin
      // Owner tags travel alongside the memory read latency.
      fetch_tag_q[0] <= fetch_issue;
      aux_tag_q[0]   <= aux_grant && !aux_we;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        fetch_tag_q[i] <= fetch_tag_q[i-1];
        aux_tag_q[i]   <= aux_tag_q[i-1];
      end

      if (!aux_req || aux_grant) begin
        starve_q <= '0;
      end else if ((state_q == StRun) && (starve_q != StarveMax)) begin
        starve_q <= starve_q + StarveW'(1);
      end

      unique case (state_q)
        StHold: state_q <= StRun;
        StRun: begin
          if (aux_grant && !aux_we) begin
            state_q    <= StAux;
            aux_left_q <= LatMax;
          end
        end
        StAux: begin
          if (aux_left_q == LatW'(1)) begin
            state_q    <= StRun;
            aux_left_q <= '0;
          end else begin
            aux_left_q <= aux_left_q - LatW'(1);
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_core_code_mem_arbiter.sv
// Scoreboard bench for the code memory arbiter: a behavioural memory plus a reference
// arbitration model predict grants, port drive and returned data.
module tb_fast_core_code_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 3;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset, sync_reset;
  logic          fetch_re_A, fetch_re_B;
  logic [AW-1:0] fetch_addr_A, fetch_addr_B;
  logic          fetch_stall, fetch_valid;
  logic [DW-1:0] fetch_data_A, fetch_data_B;
  logic          aux_req, aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_ack, aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic          mem_re_A, mem_re_B, mem_we_B;
  logic [AW-1:0] mem_addr_A, mem_addr_B;
  logic [DW-1:0] mem_wdata_B, mem_q_A, mem_q_B;

  always #5 clk = ~clk;

  fast_core_code_mem_arbiter #(
    .PC_BITWIDTH (AW),
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sync_reset  (sync_reset),
    .fetch_re_A  (fetch_re_A),
    .fetch_re_B  (fetch_re_B),
    .fetch_addr_A(fetch_addr_A),
    .fetch_addr_B(fetch_addr_B),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_data_A(fetch_data_A),
    .fetch_data_B(fetch_data_B),
    .aux_req     (aux_req),
    .aux_we      (aux_we),
    .aux_addr    (aux_addr),
    .aux_wdata   (aux_wdata),
    .aux_ack     (aux_ack),
    .aux_rvalid  (aux_rvalid),
    .aux_rdata   (aux_rdata),
    .mem_re_A    (mem_re_A),
    .mem_addr_A  (mem_addr_A),
    .mem_re_B    (mem_re_B),
    .mem_we_B    (mem_we_B),
    .mem_addr_B  (mem_addr_B),
    .mem_wdata_B (mem_wdata_B),
    .mem_q_A     (mem_q_A),
    .mem_q_B     (mem_q_B)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory driven by the DUT, and a separate golden image updated only by the model.
  logic [DW-1:0] mem     [65536];
  logic [DW-1:0] ref_mem [65536];
  logic [DW-1:0] pa [LAT];
  logic [DW-1:0] pb [LAT];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = init_val(AW'(i));
      ref_mem[i] = init_val(AW'(i));
    end
    mem[16'h1234]     = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    for (int i = 0; i < LAT; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (mem_re_A) pa[0] <= mem[mem_addr_A];
    if (mem_re_B) pb[0] <= mem[mem_addr_B];
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
    if (mem_we_B) mem[mem_addr_B] <= mem_wdata_B;
  end
  assign mem_q_A = pa[LAT-1];
  assign mem_q_B = pb[LAT-1];

  typedef struct {
    int            due;
    logic          chk_a;
    logic          chk_b;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } fexp_t;
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } aexp_t;
  fexp_t fq[$];
  aexp_t aq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: compares returned data against the scoreboard queues every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (fq.size() > 0 && fq[0].due < cyc) begin
        chk("fetch_missed", 32'(fq[0].due), 32'(cyc));
        void'(fq.pop_front());
      end
      if (fq.size() > 0 && fq[0].due == cyc) begin
        chk("fetch_valid", 32'(fetch_valid), 32'd1);
        if (fq[0].chk_a) chk("fetch_data_A", 32'(fetch_data_A), 32'(fq[0].a));
        if (fq[0].chk_b) chk("fetch_data_B", 32'(fetch_data_B), 32'(fq[0].b));
        void'(fq.pop_front());
      end else begin
        chk("fetch_valid_idle", 32'(fetch_valid), 32'd0);
      end
      while (aq.size() > 0 && aq[0].due < cyc) begin
        chk("aux_missed", 32'(aq[0].due), 32'(cyc));
        void'(aq.pop_front());
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        chk("aux_rvalid", 32'(aux_rvalid), 32'd1);
        chk("aux_rdata", 32'(aux_rdata), 32'(aq[0].d));
        void'(aq.pop_front());
      end else begin
        chk("aux_rvalid_idle", 32'(aux_rvalid), 32'd0);
      end
    end
  end

  // Reference model state: hold cycle pending, remaining aux-busy cycles, denied-aux count.
  int   m_hold, m_aux_left, m_starve;
  logic m_grant, m_stall, m_dut_ack;

  task automatic tick();
    logic  running, in_run, grant, stall, fa, fb;
    fexp_t fe;
    aexp_t ae;
    #1;
    running = !sync_reset && (m_hold == 0);
    in_run  = running && (m_aux_left == 0);
    grant   = in_run && aux_req && (!fetch_re_B || m_starve == LIM);
    stall   = grant && fetch_re_B;
    fa      = running && fetch_re_A && !stall;
    fb      = running && fetch_re_B && !grant;
    m_dut_ack = aux_ack;
    chk("aux_ack", 32'(aux_ack), 32'(grant));
    chk("fetch_stall", 32'(fetch_stall), 32'(stall));
    chk("mem_re_A", 32'(mem_re_A), 32'(fa));
    chk("mem_re_B", 32'(mem_re_B), 32'(grant ? !aux_we : fb));
    chk("mem_we_B", 32'(mem_we_B), 32'(grant && aux_we));
    if (fa) chk("mem_addr_A", 32'(mem_addr_A), 32'(fetch_addr_A));
    if (grant) chk("mem_addr_B_aux", 32'(mem_addr_B), 32'(aux_addr));
    else if (fb) chk("mem_addr_B_fetch", 32'(mem_addr_B), 32'(fetch_addr_B));
    if (grant && aux_we) chk("mem_wdata_B", 32'(mem_wdata_B), 32'(aux_wdata));
    if (fa || fb) begin
      fe.due   = cyc + LAT;
      fe.chk_a = fa;
      fe.chk_b = fb;
      fe.a     = ref_mem[fetch_addr_A];
      fe.b     = ref_mem[fetch_addr_B];
      fq.push_back(fe);
    end
    if (grant && !aux_we) begin
      ae.due = cyc + LAT;
      ae.d   = ref_mem[aux_addr];
      aq.push_back(ae);
    end
    if (grant && aux_we) ref_mem[aux_addr] = aux_wdata;

    if (!aux_req || grant) m_starve = 0;
    else if (in_run && m_starve < LIM) m_starve++;
    if (sync_reset) begin
      m_hold = 1; m_aux_left = 0; m_starve = 0;
      for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].due > cyc) fq.delete(i);
      for (int i = aq.size() - 1; i >= 0; i--) if (aq[i].due > cyc) aq.delete(i);
    end else if (m_hold != 0) begin
      m_hold = 0;
    end else if (m_aux_left > 0) begin
      m_aux_left--;
    end else if (grant && !aux_we) begin
      m_aux_left = LAT;
    end
    m_grant = grant;
    m_stall = stall;
    @(negedge clk);
  endtask

  task automatic async_reset_check();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data", 32'({fetch_data_A, fetch_data_B}), 32'd0);
    chk("rst_aux", 32'({aux_ack, aux_rvalid, aux_rdata}), 32'd0);
    chk("rst_mem_en", 32'({mem_re_A, mem_re_B, mem_we_B}), 32'd0);
    chk("rst_mem_addr", {mem_addr_A, mem_addr_B}, 32'd0);
    fq.delete();
    aq.delete();
    m_hold = 1; m_aux_left = 0; m_starve = 0;
    m_grant = 1'b0; m_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int want);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      n++;
      if (m_dut_ack) got = 1'b1;
      else if (!m_stall && fetch_re_A) begin
        fetch_addr_A = fetch_addr_A + 16'd2;
        fetch_addr_B = fetch_addr_B + 16'd2;
      end
    end
    chk(name, 32'(n), 32'(want));
    aux_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0: a = 16'hFFFF - AW'($urandom_range(0, 3));
      1: a = AW'($urandom);
      default: a = 16'h0100 + AW'($urandom_range(0, 15));
    endcase
    return a;
  endfunction

  initial begin
    reset = 1'b1; sync_reset = 1'b0;
    fetch_re_A = 1'b1; fetch_re_B = 1'b1;
    fetch_addr_A = 16'h0000; fetch_addr_B = 16'h0003;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    m_hold = 1; m_aux_left = 0; m_starve = 0;
    m_grant = 1'b0; m_stall = 1'b0; m_dut_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Continuous fetch out of reset.
    repeat (8) tick();

    // Aux read with fetch idle: zero-wait grant.
    fetch_re_A = 1'b0; fetch_re_B = 1'b0;
    repeat (LAT + 2) tick();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h1234;
    tick();
    chk("aux_zero_wait", 32'(m_dut_ack), 32'd1);
    aux_req = 1'b0;
    repeat (LAT + 2) tick();

    // Starvation: continuous fetch, aux read held.
    fetch_re_A = 1'b1; fetch_re_B = 1'b1;
    fetch_addr_A = 16'h0200; fetch_addr_B = 16'h0201;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0102;
    wait_ack("starve_wait", LIM + 1);
    repeat (LAT + 3) tick();

    // Back-to-back writes with fetch idle, then read one back.
    fetch_re_A = 1'b0; fetch_re_B = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      aux_req = 1'b1; aux_we = 1'b1;
      aux_addr = 16'h0100 + AW'(i);
      aux_wdata = DW'(8'h11 * (i + 1));
      tick();
      chk("write_ack", 32'(m_dut_ack), 32'd1);
    end
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0101;
    tick();
    aux_req = 1'b0;
    repeat (LAT + 2) tick();

    // sync_reset one cycle after an aux read grant drops the read; next grant after hold.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0100;
    tick();
    aux_req = 1'b0; sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    aux_req = 1'b1; aux_addr = 16'h0101;
    wait_ack("post_sync_wait", 2);
    repeat (LAT + 2) tick();

    // Async reset in the middle of a fetch/aux burst.
    fetch_re_A = 1'b1; fetch_re_B = 1'b1;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0105; aux_wdata = 8'hC3;
    repeat (3) tick();
    async_reset_check();
    aux_req = 1'b0;
    repeat (2) tick();

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 2000; c++) begin
      if (!m_stall) begin
        fetch_re_A   = ($urandom_range(0, 3) != 0);
        fetch_re_B   = ($urandom_range(0, 3) != 0);
        fetch_addr_A = rnd_addr();
        fetch_addr_B = rnd_addr();
      end
      if (!aux_req || m_grant) begin
        aux_req   = ($urandom_range(0, 2) == 0);
        aux_we    = $urandom_range(0, 1) == 1;
        aux_addr  = rnd_addr();
        aux_wdata = DW'($urandom);
      end
      sync_reset = ($urandom_range(0, 99) == 0);
      tick();
      sync_reset = 1'b0;
    end

    fetch_re_A = 1'b0; fetch_re_B = 1'b0; aux_req = 1'b0;
    repeat (LAT + 3) tick();
    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("aux_queue_drained", 32'(aq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fast_core_code_mem_arbiter.md
Name: fast_core_code_mem_arbiter

Overview:
Arbitrates the dual-port code memory between the two-way instruction fetch (ports A/B) and an auxiliary requester (MOVC reads, debugger/loader writes). Port A is always owned by fetch. Port B is shared between fetch and aux, with a starvation limit so aux is always served. Read data is routed back by a per-stage owner tag matched to memory latency.

Parameters:
PC_BITWIDTH, 16, code address width
DATA_WIDTH, 8, code memory word width
MEM_LATENCY, 1, memory read latency in cycles (1..3)
STARVE_LIMIT, 4, consecutive denied aux cycles before aux is forced onto port B (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active high
sync_reset  in  1  synchronous flush (core restart)
fetch_re_A  in  1  fetch read enable, port A
fetch_re_B  in  1  fetch read enable, port B
fetch_addr_A  in  PC_BITWIDTH  fetch address A
fetch_addr_B  in  PC_BITWIDTH  fetch address B
fetch_stall  out  1  fetch pair not issued this cycle; hold addresses
fetch_valid  out  1  fetch_data_A/B valid
fetch_data_A  out  DATA_WIDTH  returned fetch word A
fetch_data_B  out  DATA_WIDTH  returned fetch word B
aux_req  in  1  aux request; held with stable fields until aux_ack
aux_we  in  1  1 = write, 0 = read
aux_addr  in  PC_BITWIDTH  aux address
aux_wdata  in  DATA_WIDTH  aux write data
aux_ack  out  1  one-cycle pulse: aux request issued to port B
aux_rvalid  out  1  aux_rdata valid (reads only)
aux_rdata  out  DATA_WIDTH  aux read data
mem_re_A  out  1  memory read enable A
mem_addr_A  out  PC_BITWIDTH  memory address A
mem_re_B  out  1  memory read enable B
mem_we_B  out  1  memory write enable B
mem_addr_B  out  PC_BITWIDTH  memory address B
mem_wdata_B  out  DATA_WIDTH  memory write data B
mem_q_A  in  DATA_WIDTH  memory read data A
mem_q_B  in  DATA_WIDTH  memory read data B

Behaviour:
- reset: state S_HOLD, starve_cnt=0, owner/valid pipeline cleared, all outputs 0. sync_reset has the same effect synchronously and takes priority over all other events in that cycle.
- FSM, one-hot:
  - S_HOLD: no grants, mem_* enables 0, fetch_stall 0. Always moves to S_RUN next cycle.
  - S_RUN: normal arbitration.
  - S_AUX: one aux read in flight. Lasts MEM_LATENCY cycles, then returns to S_RUN. No new aux grant is allowed; fetch owns both ports.
- Grant rule, in S_RUN only: aux_grant = aux_req && (!fetch_re_B || starve_cnt == STARVE_LIMIT).
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) each S_RUN cycle where aux_req=1 and no grant.
  - Cleared on grant or when aux_req=0.
- Combinational port drive:
  - Port A: mem_re_A = fetch_re_A && !fetch_stall; mem_addr_A = fetch_addr_A.
  - No aux_grant: mem_re_B = fetch_re_B, mem_addr_B = fetch_addr_B, mem_we_B = 0.
  - aux_grant: mem_addr_B = aux_addr; mem_re_B = !aux_we; mem_we_B = aux_we; mem_wdata_B = aux_wdata; aux_ack = 1.
- fetch_stall = aux_grant && fetch_re_B. While stalled, port A is also suppressed so the A/B pair issues atomically. Fetch must present the same addresses next cycle.
- Aux read grant moves S_RUN to S_AUX. Aux write grant stays in S_RUN, so back-to-back writes are possible, subject to the grant rule.
- Return pipeline: MEM_LATENCY stages of {fetch_tag, aux_tag}.
  - fetch_valid asserts exactly MEM_LATENCY cycles after a cycle with mem_re_A||mem_re_B from fetch.
  - fetch_data_A = mem_q_A; fetch_data_B = mem_q_B.
  - aux_rvalid asserts exactly MEM_LATENCY cycles after the aux read ack; aux_rdata = mem_q_B.
- Simultaneous events:
  - aux_req asserted in the same cycle as starvation saturation: aux wins.
  - aux_req with fetch idle: granted with zero wait.
- A reset or sync_reset mid aux read drops the pending aux_rvalid. The requester must reissue.
- Addresses wrap naturally modulo 2^PC_BITWIDTH; no checking is done.

Test Plan:
1. Reset release; fetch_re_A/B=1, addr 0x0000/0x0003 each cycle, MEM_LATENCY=1 -> fetch_valid high from cycle 2 (S_HOLD cycle first); no stall; aux_ack 0.
2. Fetch idle, aux read at addr 0x1234, memory holds 0x5A -> aux_ack same cycle; aux_rvalid=1 with aux_rdata=0x5A one cycle later; FSM S_AUX for 1 cycle.
3. Fetch continuous, aux_req held, STARVE_LIMIT=4 -> aux_ack on 5th cycle of aux_req; fetch_stall=1 that cycle only; mem_re_A=0 that cycle; fetch_valid gap of exactly one cycle.
4. Fetch idle, three back-to-back aux writes 0x0100..0x0102, data 0x11/0x22/0x33 -> mem_we_B pulses 3 consecutive cycles with matching addr/data; aux_rvalid never asserted.
5. MEM_LATENCY=3, aux read granted, sync_reset asserted 1 cycle later -> aux_rvalid and fetch_valid stay 0; state S_HOLD then S_RUN.
6. Async reset asserted mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
